// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FIFO load-FSM states and default data width.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        GUARD = 2'd2
    } txf_state_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Circular storage for the UART TX FIFO: array, read/write pointers and level counter.
// push_i/pop_i arrive already qualified; flush_i overrides both.
module uart_tx_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              wr_en;

    assign wr_en = push_i && !flush_i;

    // Storage has no reset; nothing is read out before it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop_i && !push_i) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: FIFO plus IDLE/LOAD/GUARD load FSM strobing words into the TX shift register.
// Define UART_TX_FIFO_OVF_EN to build the sticky overflow flag; otherwise overflow reads 0.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W   = UART_DATA_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AFULL_TH = DEPTH - 1,
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_ready,
    input  logic [DATA_W-1:0] in,
    input  logic              flush,
    input  logic              sr_empty,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] out,
    output logic              out_ready,
    output logic              fifo_full,
    output logic              fifo_afull,
    output logic              fifo_empty,
    output logic [LVL_W-1:0]  level,
    output logic              overflow
);

    txf_state_t        state_q, state_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] rdata;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push_c = in_ready && (!fifo_full || pop_c);
    assign drop_c = in_ready && fifo_full && !pop_c && !flush;

    uart_tx_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .flush_i (flush),
        .wdata_i (in),
        .rdata_o (rdata),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush && !fifo_empty && sr_empty) begin
                    state_d = LOAD;
                    out_d   = rdata;
                end
            end
            LOAD: begin
                pop_c   = 1'b1;
                state_d = GUARD;
            end
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign out        = out_q;
    assign out_ready  = (state_q == LOAD);
    assign fifo_afull = (level >= LVL_W'(AFULL_TH));

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    // Set wins over clear when both happen in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop_c) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    logic ovf_unused;

    assign ovf_unused = ovf_clr | drop_c;
    assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DATA_W=8, DEPTH=4, AFULL_TH=3).
module tb_uart_tx_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
`ifdef UART_TX_FIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              in_ready;
    logic [DATA_W-1:0] in_d;
    logic              flush;
    logic              sr_empty;
    logic              ovf_clr;
    logic [DATA_W-1:0] out_d;
    logic              out_ready;
    logic              fifo_full;
    logic              fifo_afull;
    logic              fifo_empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;

    int checks;
    int errors;
    int cyc;

    uart_tx_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_ready   (in_ready),
        .in         (in_d),
        .flush      (flush),
        .sr_empty   (sr_empty),
        .ovf_clr    (ovf_clr),
        .out        (out_d),
        .out_ready  (out_ready),
        .fifo_full  (fifo_full),
        .fifo_afull (fifo_afull),
        .fifo_empty (fifo_empty),
        .level      (level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs then show the state after that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out"},   32'(out_d), 32'h0);
        check({tag, "_rdy"},   32'(out_ready), 32'h0);
        check({tag, "_full"},  32'(fifo_full), 32'h0);
        check({tag, "_afull"}, 32'(fifo_afull), 32'h0);
        check({tag, "_empty"}, 32'(fifo_empty), 32'h1);
        check({tag, "_level"}, 32'(level), 32'h0);
        check({tag, "_ovf"},   32'(overflow), 32'h0);
    endtask

    task automatic push(input logic [7:0] d);
        in_ready = 1'b1;
        in_d     = d;
        tick();
        in_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [4];
        int         idx;
        int         last;
        int         strobes;

        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1; in_ready = 1'b0; in_d = '0; flush = 1'b0;
        sr_empty = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("rst");

        // Single word: strobe two cycles after the push, lasting one cycle.
        sr_empty = 1'b1;
        push(8'hA5);
        check("a5_lvl1", 32'(level), 32'd1);
        check("a5_rdy0", 32'(out_ready), 32'd0);
        tick();
        check("a5_rdy1", 32'(out_ready), 32'd1);
        check("a5_out", 32'(out_d), 32'hA5);
        tick();
        check("a5_rdy_off", 32'(out_ready), 32'd0);
        check("a5_lvl0", 32'(level), 32'd0);
        check("a5_empty", 32'(fifo_empty), 32'd1);
        tick();
        tick();
        check("a5_no_restrobe", 32'(out_ready), 32'd0);

        // Fill with shift register busy; afull from level 3, full at 4, then drop.
        sr_empty = 1'b0;
        push(8'h11);
        push(8'h22);
        check("fill_afull_l2", 32'(fifo_afull), 32'd0);
        push(8'h33);
        check("fill_afull_l3", 32'(fifo_afull), 32'd1);
        check("fill_full_l3", 32'(fifo_full), 32'd0);
        push(8'h44);
        check("fill_lvl4", 32'(level), 32'd4);
        check("fill_full", 32'(fifo_full), 32'd1);
        push(8'h55);
        check("drop_lvl", 32'(level), 32'd4);
        check("drop_ovf", 32'(overflow), 32'(OVF_EXP));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Push coinciding with the LOAD pop on a full FIFO is accepted.
        sr_empty = 1'b1;
        tick();
        check("full_load_rdy", 32'(out_ready), 32'd1);
        check("full_load_out", 32'(out_d), 32'h11);
        last = cyc;
        push(8'h55);
        check("simul_lvl", 32'(level), 32'd4);
        check("simul_ovf", 32'(overflow), 32'd0);
        exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_ready) begin
                if (idx < 4) begin
                    check("drain_data", 32'(out_d), 32'(exp_q[idx]));
                    check("drain_gap", 32'(cyc - last), 32'd3);
                end else begin
                    check("drain_extra", 32'(out_ready), 32'd0);
                end
                last = cyc;
                idx++;
            end
            tick();
        end
        check("drain_count", 32'(idx), 32'd4);
        check("drain_empty", 32'(fifo_empty), 32'd1);

        // Flush in the LOAD cycle: strobe stands, contents vanish.
        sr_empty = 1'b0;
        push(8'h66);
        push(8'h77);
        push(8'h88);
        check("fl_lvl3", 32'(level), 32'd3);
        sr_empty = 1'b1;
        tick();
        check("fl_rdy", 32'(out_ready), 32'd1);
        check("fl_out", 32'(out_d), 32'h66);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_lvl0", 32'(level), 32'd0);
        check("fl_empty", 32'(fifo_empty), 32'd1);
        check("fl_out_kept", 32'(out_d), 32'h66);
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            strobes += int'(out_ready);
            tick();
        end
        check("fl_no_strobe", 32'(strobes), 32'd0);

        // Reset during GUARD with two words still queued.
        sr_empty = 1'b0;
        push(8'h99);
        push(8'hAA);
        push(8'hBB);
        sr_empty = 1'b1;
        tick();
        check("rg_rdy", 32'(out_ready), 32'd1);
        tick();
        check("rg_lvl2", 32'(level), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rg");
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            strobes += int'(out_ready);
            tick();
        end
        check("rg_no_strobe", 32'(strobes), 32'd0);
        check("rg_lvl_end", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised transmit data buffer for the UART: accepts bytes from the bus-side writer, stores up to DEPTH words, and hands them one at a time to the TX shift register through a one-cycle load strobe. It sits between the register interface and the TX shift register. Compared with the fixed 4×8 buffer, it adds configurable width and depth, simultaneous push/pop at full, level and almost-full status, flush, and a sticky overflow flag.

## Interface
- DATA_W, 8, data word width (5..9 legal)
- DEPTH, 4, FIFO depth; power of two, ≥2
- AFULL_TH, DEPTH-1, level at or above which fifo_afull asserts (1..DEPTH)
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- in_ready  in  1  push request; data on `in` is written when accepted
- in  in  DATA_W  push data
- flush  in  1  synchronous clear of FIFO contents and load FSM
- sr_empty  in  1  TX shift register is idle and can be loaded
- ovf_clr  in  1  clears the sticky overflow flag
- out  out  DATA_W  registered word presented to the shift register
- out_ready  out  1  one-cycle load strobe; shift register captures `out`
- fifo_full  out  1  level == DEPTH
- fifo_afull  out  1  level ≥ AFULL_TH
- fifo_empty  out  1  level == 0
- level  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: a push was dropped

## Operation
- Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally at DEPTH; separate level counter of $clog2(DEPTH+1) bits.
- Push is accepted when in_ready && (!fifo_full || pop this cycle). On acceptance mem[wr_ptr] <= in and wr_ptr++.
- Drop: in_ready && fifo_full && no pop. The word is discarded, no state changes, and overflow is set.
- Load FSM states: IDLE, LOAD, GUARD.
  - IDLE → LOAD when !fifo_empty && sr_empty; on that edge out <= mem[rd_ptr].
  - LOAD: out_ready=1 for exactly this cycle; pop (rd_ptr++, level−1) at the end of the cycle; → GUARD.
  - GUARD: out_ready=0; one cycle unconditionally; → IDLE. The shift register must deassert sr_empty within one cycle of the strobe.
- level update per edge: +1 on push only, −1 on pop only, unchanged on both.
- A word pushed into an empty FIFO becomes eligible for load on the next cycle; there is no bypass.
- flush: has priority over push and pop; pointers and level go to 0 and the FSM goes to IDLE. `out` and overflow are unchanged. A flush during LOAD cancels that pop. The strobe already asserted this cycle still stands, so the shift register takes `out`.
- overflow: set on a drop, cleared by ovf_clr; set wins if both occur in the same cycle.

## Timing
- Reset values: out=0, out_ready=0, fifo_full=0, fifo_afull=0 (or 1 if AFULL_TH==0, which is illegal), fifo_empty=1, level=0, overflow=0; FSM=IDLE.
- Reset mid-operation discards all contents, including a pending LOAD.
- All status outputs are decoded from registered level and reflect the state after the last edge.
- Latency from push into an empty FIFO (with sr_empty high) to out_ready is 2 cycles. With sr_empty continuously high, the sustained rate is one load per 3 cycles.
- mem has no reset; contents are undefined after reset and are never output before a push.

## Configuration
- UART_TX_FIFO_OVF_EN defined: overflow and ovf_clr behave as described.
- UART_TX_FIFO_OVF_EN undefined: the overflow register is not built, overflow is tied 0, and ovf_clr is ignored. Drop behaviour is unchanged: the word is discarded silently.

## Structure
- Package uart_pkg holds the FSM state enum (txf_state_t: IDLE, LOAD, GUARD) and the default width constant UART_DATA_W=8.
- Sub-module uart_tx_fifo_mem contains the storage array, pointers, and level counter with push/pop/flush inputs. The top level holds the load FSM, the `out` register, and the overflow logic.

## Test plan
- Reset, then push 0xA5 with sr_empty=1 → out=0xA5 and out_ready high for 1 cycle 2 cycles later; level goes 1→0 and fifo_empty returns to 1.
- DEPTH=4 with sr_empty=0: push 0x11,0x22,0x33,0x44 → level=4, fifo_full=1, fifo_afull asserted from level 3; a fifth push 0x55 → dropped and overflow=1; ovf_clr → overflow=0.
- Full FIFO: raise sr_empty so that a push of 0x55 coincides with the LOAD cycle → push accepted and level stays 4. Draining then yields 0x11,0x22,0x33,0x44,0x55 in order, including across the pointer wrap.
- Flush asserted in the LOAD cycle with level=3 → out_ready still pulses with the current out, then level=0, fifo_empty=1, and no further strobes.
- rst asserted with level=2 mid-GUARD → all outputs at their reset values on the next cycle and no further strobes. With UART_TX_FIFO_OVF_EN undefined, the overflow scenario shows overflow stuck at 0.
